multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle sequencer for the RISC-V datapath. It replaces the single-cycle opcode decoder with a Moore FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB phases and drives the shared-memory, register-file, ALU-mux and PC strobes. Memory accesses use a request/ready handshake, bounded by a timeout. It supports lb, sb, R-type (add/and/sll), ori and bne, flags illegal opcodes, and counts retired instructions.

Parameters:
TIMEOUT, 15, maximum cycles a memory request may wait for MemReady before faulting (1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
Opcode  input  7  IR[6:0]; valid from DECODE onward, stable until next FETCH completes
MemReady  input  1  memory accepts/completes current MemRead/MemWrite this cycle
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load instruction register
PCWrite  output  1  unconditional PC load (PC+4)
Branch  output  1  conditional PC load; datapath loads the PC when Branch && !Zero (bne)
PCSource  output  1  PC source: 0 = ALU result, 1 = ALUOut (branch target)
ALUSrcA  output  1  ALU A operand: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = immediate
ALUOp  output  3  000 add, 001 branch compare, 010 R-type funct decode, 011 I-type logic
RegWrite  output  1  register file write enable
MemtoReg  output  1  writeback source: 0 = ALUOut, 1 = MDR
InstrDone  output  1  one-cycle pulse on the final cycle of each instruction
InstrCount  output  CNT_W  retired instructions; wraps at 2^CNT_W
Illegal  output  1  sticky: an undecoded opcode was seen
Timeout  output  1  sticky: a memory wait reached TIMEOUT

Behaviour:
- Reset (rst_n low, asynchronous): state=RST, wait counter=0, InstrCount=0, Illegal=0, Timeout=0. All strobes are 0 while in RST, ALUSrcB=00, ALUOp=000.
- Reset mid-operation aborts the instruction immediately with no partial writeback. Release goes RST -> FETCH on the next edge.
- Outputs decode combinationally from state. The only exceptions are IRWrite, PCWrite and InstrDone in memory states, which are additionally gated by MemReady.
- Opcode decode: 0000011 lb, 0100011 sb, 0110011 R-type, 0010011 ori, 1100011 bne. Any other value is illegal.
- Default value for every strobe is 0.
- States and transitions:
  - RST: all outputs 0. Next -> FETCH.
  - FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, IRWrite=PCWrite=MemReady. Stays while !MemReady. Next -> DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=000 (branch target into ALUOut). Next: lb/sb -> ADDR; R/ori -> EXEC; bne -> BRANCH; illegal -> TRAP with Illegal set.
  - ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next: lb -> MEMRD; sb -> MEMWR.
  - MEMRD: IorD=1, MemRead=1. Waits for MemReady. Next -> WBMEM.
  - WBMEM: RegWrite=1, MemtoReg=1, InstrDone=1. Next -> FETCH.
  - MEMWR: IorD=1, MemWrite=1, InstrDone=MemReady. Waits for MemReady. Next -> FETCH.
  - EXEC: ALUSrcA=1. R-type: ALUSrcB=00, ALUOp=010. ori: ALUSrcB=10, ALUOp=011. Next -> WBALU.
  - WBALU: RegWrite=1, MemtoReg=0, InstrDone=1. Next -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, Branch=1, PCSource=1, InstrDone=1. Next -> FETCH.
  - TRAP: all strobes 0. Held until reset.
- Wait counter: cleared on entry to FETCH, MEMRD and MEMWR, and whenever MemReady=1. It increments on each cycle in those states with MemReady=0.
  - When the counter reaches TIMEOUT with MemReady still 0, next state is TRAP and Timeout is set.
  - If MemReady=1 on the same cycle the limit is reached, MemReady wins and there is no fault.
- InstrCount increments on every edge where InstrDone=1 and wraps to 0 from all-ones. Illegal and timeout-faulted instructions are not counted.
- Minimum latencies with MemReady tied 1: R/ori 4 cycles, bne 3, sb 4, lb 5. Each extra MemReady=0 cycle adds 1.
- MemRead and MemWrite are never both 1. IRWrite is never 1 outside FETCH.

Test Plan:
- Reset release, MemReady=1, Opcode=0110011 -> states RST,FETCH,DECODE,EXEC,WBALU; ALUOp=010 in EXEC; RegWrite=1 in WBALU only; InstrCount=1 after 5 edges.
- lb (0000011), MemReady low 2 cycles in MEMRD -> MemRead/IorD=1 held 3 cycles; WBMEM asserts RegWrite=1, MemtoReg=1; total 7 cycles.
- sb (0100011) then ori (0010011) back-to-back -> MemWrite=1 exactly 1 cycle; ori EXEC shows ALUSrcB=10, ALUOp=011; InstrCount=2.
- bne (1100011) -> BRANCH cycle has Branch=1, PCSource=1, ALUOp=001, PCWrite=0; InstrDone pulses once.
- Opcode=1111111 -> TRAP after DECODE; Illegal=1; all strobes 0 for 20 further cycles; InstrCount unchanged.
- TIMEOUT=3, MemReady=0 in FETCH -> TRAP after 3 waits, Timeout=1. Separate run: rst_n low mid-MEMRD -> MemRead drops immediately (async); InstrCount=0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencer for the multi-cycle RISC-V datapath
module multicycle_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Opcode,
  input  logic             MemReady,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             InstrDone,
  output logic [CNT_W-1:0] InstrCount,
  output logic             Illegal,
  output logic             Timeout
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_ADDR, S_MEMRD, S_WBMEM,
    S_MEMWR, S_EXEC, S_WBALU, S_BRANCH, S_TRAP
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic is_lb, is_sb, is_r, is_ori, is_bne;
  logic wait_expired;

  assign is_lb  = (Opcode == 7'b0000011);
  assign is_sb  = (Opcode == 7'b0100011);
  assign is_r   = (Opcode == 7'b0110011);
  assign is_ori = (Opcode == 7'b0010011);
  assign is_bne = (Opcode == 7'b1100011);

  // A memory wait faults only if this cycle would be the TIMEOUT-th stall; MemReady beats the limit.
  assign wait_expired = !MemReady && (wait_q == WAIT_LAST);

  assign InstrCount = instr_count_q;
  assign Illegal    = illegal_q;
  assign Timeout    = timeout_q;

  // State, wait counter, retire counter and sticky faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RST;
      wait_q        <= '0;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic; the wait counter only survives a stalled memory cycle.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    instr_count_d = InstrDone ? instr_count_q + CNT_W'(1) : instr_count_q;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (MemReady) begin
          if (state_q == S_FETCH)      state_d = S_DECODE;
          else if (state_q == S_MEMRD) state_d = S_WBMEM;
          else                         state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (is_lb || is_sb)       state_d = S_ADDR;
        else if (is_r || is_ori)  state_d = S_EXEC;
        else if (is_bne)          state_d = S_BRANCH;
        else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_ADDR:   state_d = is_lb ? S_MEMRD : S_MEMWR;
      S_WBMEM:  state_d = S_FETCH;
      S_EXEC:   state_d = S_WBALU;
      S_WBALU:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Moore strobes decoded from state; memory states also gate on MemReady.
  always_comb begin
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    PCSource  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 3'b000;
    RegWrite  = 1'b0;
    MemtoReg  = 1'b0;
    InstrDone = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b10;
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_WBMEM: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (is_r) begin
          ALUSrcB = 2'b00;
          ALUOp   = 3'b010;
        end else begin
          ALUSrcB = 2'b10;
          ALUOp   = 3'b011;
        end
      end
      S_WBALU: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 3'b001;
        Branch    = 1'b1;
        PCSource  = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed-vector bench for multicycle_control
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] Opcode;
  logic       MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, PCSource, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       RegWrite, MemtoReg, InstrDone;
  logic [3:0] InstrCount;
  logic       Illegal, Timeout;

  int checks;
  int failures;

  multicycle_control #(.TIMEOUT(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .InstrDone(InstrDone), .InstrCount(InstrCount), .Illegal(Illegal), .Timeout(Timeout)
  );

  // {IorD,MemRead,MemWrite,IRWrite,PCWrite,Branch,PCSource,ALUSrcA,ALUSrcB,ALUOp,RegWrite,MemtoReg,InstrDone}
  logic [15:0] outs;
  assign outs = {IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, PCSource, ALUSrcA,
                 ALUSrcB, ALUOp, RegWrite, MemtoReg, InstrDone};

  localparam logic [15:0] O_NONE    = 16'b0_0_0_0_0_0_0_0_00_000_0_0_0;
  localparam logic [15:0] O_FETCH_R = 16'b0_1_0_1_1_0_0_0_01_000_0_0_0;
  localparam logic [15:0] O_FETCH_W = 16'b0_1_0_0_0_0_0_0_01_000_0_0_0;
  localparam logic [15:0] O_DECODE  = 16'b0_0_0_0_0_0_0_0_10_000_0_0_0;
  localparam logic [15:0] O_ADDR    = 16'b0_0_0_0_0_0_0_1_10_000_0_0_0;
  localparam logic [15:0] O_MEMRD   = 16'b1_1_0_0_0_0_0_0_00_000_0_0_0;
  localparam logic [15:0] O_WBMEM   = 16'b0_0_0_0_0_0_0_0_00_000_1_1_1;
  localparam logic [15:0] O_MEMWR_R = 16'b1_0_1_0_0_0_0_0_00_000_0_0_1;
  localparam logic [15:0] O_MEMWR_W = 16'b1_0_1_0_0_0_0_0_00_000_0_0_0;
  localparam logic [15:0] O_EXEC_R  = 16'b0_0_0_0_0_0_0_1_00_010_0_0_0;
  localparam logic [15:0] O_EXEC_I  = 16'b0_0_0_0_0_0_0_1_10_011_0_0_0;
  localparam logic [15:0] O_WBALU   = 16'b0_0_0_0_0_0_0_0_00_000_1_0_1;
  localparam logic [15:0] O_BRANCH  = 16'b0_0_0_0_0_1_1_1_00_001_0_0_1;

  localparam logic [6:0] OP_LB  = 7'b0000011;
  localparam logic [6:0] OP_SB  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_ORI = 7'b0010011;
  localparam logic [6:0] OP_BNE = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive MemReady, check strobes mid-cycle, then cross the edge.
  task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
    MemReady = rdy;
    #1;
    check(tag, {16'd0, outs}, {16'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_r(input string tag);
    Opcode = OP_R;
    cyc({tag, "_fetch"}, 1'b1, O_FETCH_R);
    cyc({tag, "_decode"}, 1'b1, O_DECODE);
    cyc({tag, "_exec"}, 1'b1, O_EXEC_R);
    cyc({tag, "_wbalu"}, 1'b1, O_WBALU);
  endtask

  task automatic do_bne(input string tag);
    Opcode = OP_BNE;
    cyc({tag, "_fetch"}, 1'b1, O_FETCH_R);
    cyc({tag, "_decode"}, 1'b1, O_DECODE);
    cyc({tag, "_branch"}, 1'b1, O_BRANCH);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    MemReady = 1'b0;
    Opcode   = 7'd0;
    #3;

    // Reset state
    cyc("rst_outs", 1'b1, O_NONE);
    check("rst_count", 32'(InstrCount), 32'd0);
    check("rst_illegal", 32'(Illegal), 32'd0);
    check("rst_timeout", 32'(Timeout), 32'd0);
    rst_n = 1'b1;
    cyc("rel_rst", 1'b1, O_NONE);

    // R-type, 4 cycles
    do_r("r1");
    check("r1_count", 32'(InstrCount), 32'd1);

    // lb with two stalls in MEMRD: 7 cycles
    Opcode = OP_LB;
    cyc("lb_fetch", 1'b1, O_FETCH_R);
    cyc("lb_decode", 1'b1, O_DECODE);
    cyc("lb_addr", 1'b1, O_ADDR);
    cyc("lb_memrd0", 1'b0, O_MEMRD);
    cyc("lb_memrd1", 1'b0, O_MEMRD);
    cyc("lb_memrd2", 1'b1, O_MEMRD);
    cyc("lb_wbmem", 1'b1, O_WBMEM);
    check("lb_count", 32'(InstrCount), 32'd2);

    // sb then ori back-to-back
    Opcode = OP_SB;
    cyc("sb_fetch", 1'b1, O_FETCH_R);
    cyc("sb_decode", 1'b1, O_DECODE);
    cyc("sb_addr", 1'b1, O_ADDR);
    cyc("sb_memwr", 1'b1, O_MEMWR_R);
    Opcode = OP_ORI;
    cyc("ori_fetch", 1'b1, O_FETCH_R);
    cyc("ori_decode", 1'b1, O_DECODE);
    cyc("ori_exec", 1'b1, O_EXEC_I);
    cyc("ori_wbalu", 1'b1, O_WBALU);
    check("sbori_count", 32'(InstrCount), 32'd4);

    // bne
    do_bne("bne");
    check("bne_count", 32'(InstrCount), 32'd5);

    // sb stalled TIMEOUT-1 cycles, ready on the limit cycle: no fault
    Opcode = OP_SB;
    cyc("sbw_fetch", 1'b1, O_FETCH_R);
    cyc("sbw_decode", 1'b1, O_DECODE);
    cyc("sbw_addr", 1'b1, O_ADDR);
    cyc("sbw_memwr0", 1'b0, O_MEMWR_W);
    cyc("sbw_memwr1", 1'b0, O_MEMWR_W);
    cyc("sbw_memwr2", 1'b1, O_MEMWR_R);
    check("sbw_timeout", 32'(Timeout), 32'd0);
    check("sbw_count", 32'(InstrCount), 32'd6);

    // bne with two stalls in FETCH
    Opcode = OP_BNE;
    cyc("bnew_fetch0", 1'b0, O_FETCH_W);
    cyc("bnew_fetch1", 1'b0, O_FETCH_W);
    cyc("bnew_fetch2", 1'b1, O_FETCH_R);
    cyc("bnew_decode", 1'b1, O_DECODE);
    cyc("bnew_branch", 1'b1, O_BRANCH);
    check("bnew_timeout", 32'(Timeout), 32'd0);
    check("bnew_count", 32'(InstrCount), 32'd7);

    // Counter wraps from 15 to 0 (4-bit)
    for (int i = 0; i < 9; i++) do_bne("wrap");
    check("wrap_count", 32'(InstrCount), 32'd0);
    do_r("r2");
    check("r2_count", 32'(InstrCount), 32'd1);

    // Illegal opcode traps and holds
    Opcode = OP_BAD;
    cyc("ill_fetch", 1'b1, O_FETCH_R);
    cyc("ill_decode", 1'b1, O_DECODE);
    check("ill_flag", 32'(Illegal), 32'd1);
    for (int i = 0; i < 20; i++) cyc("ill_trap", (i % 2) == 0, O_NONE);
    check("ill_count", 32'(InstrCount), 32'd1);
    check("ill_timeout", 32'(Timeout), 32'd0);

    // Async reset clears sticky flags without waiting for an edge
    rst_n = 1'b0;
    #1;
    check("ill_rst_flag", 32'(Illegal), 32'd0);
    check("ill_rst_count", 32'(InstrCount), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("to_rst", 1'b1, O_NONE);

    // FETCH stalls TIMEOUT cycles -> TRAP
    Opcode = OP_R;
    cyc("to_fetch0", 1'b0, O_FETCH_W);
    cyc("to_fetch1", 1'b0, O_FETCH_W);
    check("to_pre", 32'(Timeout), 32'd0);
    cyc("to_fetch2", 1'b0, O_FETCH_W);
    check("to_flag", 32'(Timeout), 32'd1);
    cyc("to_trap0", 1'b1, O_NONE);
    cyc("to_trap1", 1'b1, O_NONE);
    check("to_illegal", 32'(Illegal), 32'd0);
    check("to_count", 32'(InstrCount), 32'd0);

    // Reset mid-MEMRD
    rst_n = 1'b0;
    #1;
    check("to_rst_flag", 32'(Timeout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("mr_rst", 1'b1, O_NONE);
    do_r("mr_r");
    check("mr_count_pre", 32'(InstrCount), 32'd1);
    Opcode = OP_LB;
    cyc("mr_fetch", 1'b1, O_FETCH_R);
    cyc("mr_decode", 1'b1, O_DECODE);
    cyc("mr_addr", 1'b1, O_ADDR);
    MemReady = 1'b0;
    #1;
    check("mr_memread_on", 32'(MemRead), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_memread_off", 32'(MemRead), 32'd0);
    check("mr_outs", 32'(outs), 32'd0);
    check("mr_count", 32'(InstrCount), 32'd0);
    @(posedge clk);
    #1;
    MemReady = 1'b1;
    #1;
    check("mr_wb_blocked", 32'(RegWrite), 32'd0);
    rst_n = 1'b1;
    cyc("mr_rel", 1'b1, O_NONE);
    do_r("mr_after");
    check("mr_after_count", 32'(InstrCount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
